// File: rtl/raster_reassembler_if.sv
// rtl/raster_reassembler_if.sv - kernel-result in / framed raster out bundle
interface raster_reassembler_if;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] kern_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic       busy;
    logic       err;

    modport master (
        output in_valid, in_sof, kern_data,
        input  out_valid, out_data, out_sof, out_eol, out_eof, busy, err
    );

    modport slave (
        input  in_valid, in_sof, kern_data,
        output out_valid, out_data, out_sof, out_eol, out_eof, busy, err
    );
endinterface

// File: rtl/raster_reassembler.sv
// rtl/raster_reassembler.sv - realigns 3x3 kernel results to centre pixels and frames the raster
module raster_reassembler #(
    parameter int         W          = 3124,
    parameter int         H          = 3124,
    parameter int         KLAT       = 2,
    parameter logic [7:0] BORDER_VAL = 8'h00
) (
    input logic                   clk,
    input logic                   rst_n,
    raster_reassembler_if.slave   bus
);
    localparam int N  = W * H;
    localparam int NW = $clog2(N + 1);
    localparam int FW = $clog2(W + 2);
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, ACCUM, STREAM, FLUSH} state_t;

    state_t          state, state_next;
    logic [NW-1:0]   n_cnt, n_next;
    logic [FW-1:0]   flush_cnt, flush_next;
    logic            err_q, err_next;
    logic            push, push_first, discard, sof_in;
    logic [KLAT-1:0] sr_valid, sr_first;
    logic [RW-1:0]   row, cur_r;
    logic [CW-1:0]   col, cur_c;
    logic            border, out_go;

    assign sof_in   = bus.in_valid && bus.in_sof;
    assign bus.busy = (state != IDLE);
    assign bus.err  = err_q;

    // Flush pushes run off their own counter so a new frame can start accumulating meanwhile.
    always_comb begin
        state_next = state;
        n_next     = n_cnt;
        flush_next = flush_cnt;
        err_next   = err_q;
        push       = 1'b0;
        push_first = 1'b0;
        discard    = 1'b0;
        if (flush_cnt != '0) begin
            push       = 1'b1;
            flush_next = flush_cnt - FW'(1);
        end
        case (state)
            IDLE: begin
                if (sof_in) begin
                    state_next = ACCUM;
                    n_next     = NW'(1);
                    err_next   = 1'b0;
                end
            end
            ACCUM, STREAM: begin
                if (!bus.in_valid) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (bus.in_sof) begin
                    err_next   = 1'b1;
                    discard    = (state == STREAM);
                    state_next = ACCUM;
                    n_next     = NW'(1);
                end else begin
                    n_next = n_cnt + NW'(1);
                    if (state == ACCUM) begin
                        if (n_cnt == NW'(W)) state_next = STREAM;
                    end else begin
                        push       = 1'b1;
                        push_first = (n_cnt == NW'(W + 1));
                        if (n_cnt == NW'(N - 1)) begin
                            state_next = FLUSH;
                            flush_next = FW'(W + 1);
                        end
                    end
                end
            end
            FLUSH: begin
                if (sof_in) begin
                    state_next = ACCUM;
                    n_next     = NW'(1);
                    err_next   = 1'b0;
                end else if (bus.out_valid && bus.out_eof) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first-output tag restarts the coordinate counters, so a drained or aborted frame never skews the next one.
    always_comb begin
        out_go = sr_valid[KLAT-1] && !discard;
        cur_r  = sr_first[KLAT-1] ? '0 : row;
        cur_c  = sr_first[KLAT-1] ? '0 : col;
        border = (cur_r == '0) || (cur_r == RW'(H - 1)) ||
                 (cur_c == '0) || (cur_c == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            n_cnt         <= '0;
            flush_cnt     <= '0;
            err_q         <= 1'b0;
            sr_valid      <= '0;
            sr_first      <= '0;
            row           <= '0;
            col           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_sof   <= 1'b0;
            bus.out_eol   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else begin
            state     <= state_next;
            n_cnt     <= n_next;
            flush_cnt <= discard ? '0 : flush_next;
            err_q     <= err_next;
            sr_valid[0] <= push && !discard;
            sr_first[0] <= push_first;
            for (int k = 1; k < KLAT; k++) begin
                sr_valid[k] <= sr_valid[k-1] && !discard;
                sr_first[k] <= sr_first[k-1];
            end
            bus.out_valid <= out_go;
            bus.out_sof   <= out_go && (cur_r == '0) && (cur_c == '0);
            bus.out_eol   <= out_go && (cur_c == CW'(W - 1));
            bus.out_eof   <= out_go && (cur_r == RW'(H - 1)) && (cur_c == CW'(W - 1));
            if (out_go) bus.out_data <= border ? BORDER_VAL : bus.kern_data;
            if (sr_valid[KLAT-1]) begin
                if (cur_c == CW'(W - 1)) begin
                    col <= '0;
                    row <= (cur_r == RW'(H - 1)) ? '0 : cur_r + RW'(1);
                end else begin
                    col <= cur_c + CW'(1);
                    row <= cur_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_raster_reassembler.sv
// tb/tb_raster_reassembler.sv - frame-level model and directed scenarios for raster_reassembler
module tb_raster_reassembler;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int KLAT = 2;
    localparam int N    = W * H;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vec = 0;
    int   bad = 0;
    bit   kmode;

    raster_reassembler_if bus ();
    raster_reassembler #(.W(W), .H(H), .KLAT(KLAT), .BORDER_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectations are keyed by the clock edge on which the output is first sampled.
    bit         exp_v    [int];
    int         exp_m    [int];
    int         exp_f    [int];
    bit         exp_busy [int];
    bit         exp_err  [int];
    logic [7:0] kern_at  [int];
    bit m_in, m_err;
    int m_n, m_fid, m_busy_end;

    int n_pulse, n_zero, n_a5, n_eol, n_eof, n_sof, first_p;
    int obs_data [N];

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got 'h%0h, required 'h%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_v.delete(); exp_m.delete(); exp_f.delete();
        exp_busy.delete(); exp_err.delete();
        m_in = 0; m_err = 0; m_n = 0; m_busy_end = 0;
    endtask

    task automatic sched(input int p, input int m);
        exp_v[p] = 1'b1; exp_m[p] = m; exp_f[p] = m_fid;
    endtask

    task automatic model_edge(input int e, input bit v, input bit s);
        int drop[$];
        if (m_in) begin
            if (!v) begin
                m_in = 0; m_err = 1; m_busy_end = 0;
            end else if (s) begin
                m_err = 1;
                foreach (exp_v[k]) if (k > e && exp_f[k] == m_fid) drop.push_back(k);
                foreach (drop[i]) begin exp_v.delete(drop[i]); exp_m.delete(drop[i]); exp_f.delete(drop[i]); end
                m_fid++; m_n = 1;
            end else begin
                if (m_n >= W + 1) sched(e + KLAT + 1, m_n - W - 1);
                if (m_n == N - 1) begin
                    for (int j = 0; j <= W; j++) sched(e + KLAT + 2 + j, N - W - 1 + j);
                    m_busy_end = e + KLAT + 3 + W;
                    m_in = 0;
                end
                m_n++;
            end
        end else if (v && s) begin
            m_in = 1; m_n = 1; m_err = 0; m_fid++;
        end
        exp_busy[e+1] = m_in || (e + 1 < m_busy_end);
        exp_err[e+1]  = m_err;
    endtask

    task automatic compare();
        int p, m, r, c;
        bit ev, eb, ee;
        logic [7:0] ed;
        p  = cyc + 1;
        ev = exp_v.exists(p);
        eb = exp_busy.exists(p) ? exp_busy[p] : 1'b0;
        ee = exp_err.exists(p) ? exp_err[p] : 1'b0;
        chk("valid_busy_err", {bus.out_valid, bus.busy, bus.err}, {ev, eb, ee});
        if (ev && bus.out_valid) begin
            m  = exp_m[p]; r = m / W; c = m % W;
            ed = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 8'h00
                 : (kern_at.exists(p - 1) ? kern_at[p-1] : 8'hxx);
            chk("pixel_data_sof_eol_eof",
                {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof},
                {ed, m == 0, c == W - 1, m == N - 1});
            obs_data[m] = int'(bus.out_data);
        end
        if (bus.out_valid) begin
            n_pulse++;
            if (bus.out_data == 8'h00) n_zero++;
            if (bus.out_data == 8'hA5) n_a5++;
            if (bus.out_eol) n_eol++;
            if (bus.out_eof) n_eof++;
            if (bus.out_sof) begin n_sof++; first_p = p; end
        end
    endtask

    task automatic step(input bit v, input bit s);
        int e;
        logic [7:0] kv;
        e  = cyc + 1;
        kv = kmode ? 8'(e) : 8'hA5;
        bus.in_valid = v; bus.in_sof = s; bus.kern_data = kv;
        kern_at[e] = kv;
        model_edge(e, v, s);
        @(posedge clk); #2;
    endtask

    task automatic frame_in(input int count);
        for (int i = 0; i < count; i++) step(1'b1, i == 0);
    endtask

    task automatic idle(input int count);
        for (int i = 0; i < count; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        int b_pulse, b_zero, b_a5, b_eol, b_eof, b_sof, s0;
        rst_n = 1'b0; kmode = 1'b0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.kern_data = 8'h00;
        n_pulse = 0; n_zero = 0; n_a5 = 0; n_eol = 0; n_eof = 0; n_sof = 0; first_p = 0;
        m_fid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, bus.busy, bus.err}, 0);
        rst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) compare();
            end
        join_none

        // Constant kernel value: border/interior split and markers.
        b_pulse = n_pulse; b_zero = n_zero; b_a5 = n_a5; b_eol = n_eol; b_eof = n_eof; b_sof = n_sof;
        frame_in(N); idle(20);
        chk("f1_pulses", n_pulse - b_pulse, 48);
        chk("f1_border", n_zero - b_zero, 24);
        chk("f1_interior", n_a5 - b_a5, 24);
        chk("f1_eol", n_eol - b_eol, 6);
        chk("f1_eof", n_eof - b_eof, 1);
        chk("f1_sof", n_sof - b_sof, 1);
        chk("f1_busy_idle", bus.busy, 0);

        // Cycle-count kernel value pins alignment and first-output latency.
        kmode = 1'b1;
        s0 = cyc + 1;
        frame_in(N); idle(20);
        chk("f2_latency", first_p - s0, 12);
        chk("f2_m9_data", obs_data[9], (s0 + 18 + 2) & 8'hFF);
        kmode = 1'b0;

        // Gap at input 30: drain only, no eof, then a clean frame clears err.
        b_pulse = n_pulse; b_eof = n_eof;
        frame_in(30); idle(10);
        chk("gap_pulses", n_pulse - b_pulse, 21);
        chk("gap_no_eof", n_eof - b_eof, 0);
        chk("gap_err", bus.err, 1);
        chk("gap_idle", bus.busy, 0);
        b_pulse = n_pulse; b_eof = n_eof;
        frame_in(N); idle(20);
        chk("gap_next_pulses", n_pulse - b_pulse, 48);
        chk("gap_next_eof", n_eof - b_eof, 1);
        chk("gap_err_cleared", bus.err, 0);

        // Early sof at input 20: old outputs stop after m=8, new frame complete.
        b_pulse = n_pulse; b_eof = n_eof; b_sof = n_sof;
        frame_in(20); frame_in(N); idle(20);
        chk("early_pulses", n_pulse - b_pulse, 57);
        chk("early_sof", n_sof - b_sof, 2);
        chk("early_eof", n_eof - b_eof, 1);
        chk("early_err", bus.err, 1);

        // Back-to-back frames: sof lands during the flush.
        b_pulse = n_pulse; b_eof = n_eof;
        frame_in(N); frame_in(N); idle(20);
        chk("b2b_pulses", n_pulse - b_pulse, 96);
        chk("b2b_eof", n_eof - b_eof, 2);
        chk("b2b_err", bus.err, 0);

        // Asynchronous reset mid-stream.
        frame_in(25);
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        model_reset();
        #1;
        chk("midrst_outputs", {bus.out_valid, bus.busy, bus.err}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(5);
        b_eof = n_eof; b_pulse = n_pulse;
        frame_in(N); idle(20);
        chk("post_rst_pulses", n_pulse - b_pulse, 48);
        chk("post_rst_eof", n_eof - b_eof, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
